// File: rtl/pixel_color_pkg.sv
// pixel_color_pkg
// Shared constants and types for the pixel colour generator:
//   - display geometry and default sprite sizes
//   - 3-bit colour codes understood by the monitor stage
//   - object-id map for the update port
//   - obj_rec_t, the {active, x, y} record held per object in both banks
package pixel_color_pkg;

    localparam int H_DISPLAY = 640;
    localparam int V_DISPLAY = 480;

    localparam int PLAYER_W = 32;
    localparam int PLAYER_H = 16;
    localparam int ENEMY_W  = 32;
    localparam int ENEMY_H  = 16;
    localparam int BULLET_W = 4;
    localparam int BULLET_H = 8;

    localparam logic [2:0] COL_BG      = 3'b000;
    localparam logic [2:0] COL_PLAYER  = 3'b001;
    localparam logic [2:0] COL_PBULLET = 3'b010;
    localparam logic [2:0] COL_EBULLET = 3'b011;
    localparam logic [2:0] COL_ENEMY   = 3'b100;

    // Object ids; enemy bullets occupy ID_EBULLET0 .. ID_EBULLET0+N_EBULLET-1
    localparam int ID_PLAYER   = 0;
    localparam int ID_PBULLET  = 1;
    localparam int ID_ENEMY    = 2;
    localparam int ID_EBULLET0 = 3;

    typedef struct packed {
        logic       active;
        logic [9:0] x;
        logic [9:0] y;
    } obj_rec_t;

    localparam obj_rec_t OBJ_RESET = '{active: 1'b0, x: 10'd0, y: 10'd0};

endpackage

// File: rtl/pixel_color_gen_sprite_hit.sv
// sprite_hit
// Rectangle hit test for one object against the current pixel.
// Ports:
//   pix_x, pix_y      current pixel coordinate
//   obj_active        object visible
//   obj_x, obj_y      object top-left corner
//   hit               pixel lies inside the W x H rectangle of an active object
// The right/bottom bounds are formed in 11 bits so an object near the edge
// never wraps back to column/line 0; anything past the display is clipped
// later by the in-display check.
module sprite_hit
    import pixel_color_pkg::*;
#(
    parameter int W = 32,
    parameter int H = 16
) (
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       obj_active,
    input  logic [9:0] obj_x,
    input  logic [9:0] obj_y,
    output logic       hit
);

    logic [10:0] x_end_s;
    logic [10:0] y_end_s;
    logic        in_x_s;
    logic        in_y_s;

    assign x_end_s = {1'b0, obj_x} + 11'(W);
    assign y_end_s = {1'b0, obj_y} + 11'(H);

    assign in_x_s = (pix_x >= obj_x) && ({1'b0, pix_x} < x_end_s);
    assign in_y_s = (pix_y >= obj_y) && ({1'b0, pix_y} < y_end_s);

    assign hit = obj_active && in_x_s && in_y_s;

endmodule

// File: rtl/pixel_color_gen.sv
// pixel_color_gen
// Turns the current pixel coordinate into a 3-bit colour code for the
// monitor, drawing the player, player bullet, enemy and enemy bullets.
// Ports:
//   i_Clk, i_Reset                 clock, synchronous active-high reset
//   i_Pix_En, i_Pix_X, i_Pix_Y     pixel strobe and coordinate
//   i_Wr_Valid/o_Wr_Ready          object update handshake
//   i_Wr_Id, i_Wr_X, i_Wr_Y,
//   i_Wr_Active                    update payload
//   o_Pixel_Color                  colour code, two strobes after the pixel
//   o_Frame_Start                  one-cycle pulse after the bank commit
// Updates land in a staging bank and are copied to the drawing (shadow) bank
// at pixel (0, V_DISPLAY), i.e. the start of vertical blanking, so a visible
// frame never mixes old and new positions.
module pixel_color_gen
    import pixel_color_pkg::*;
#(
    parameter int N_EBULLET = 4
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Pix_En,
    input  logic [9:0] i_Pix_X,
    input  logic [9:0] i_Pix_Y,
    input  logic       i_Wr_Valid,
    output logic       o_Wr_Ready,
    input  logic [3:0] i_Wr_Id,
    input  logic [9:0] i_Wr_X,
    input  logic [9:0] i_Wr_Y,
    input  logic       i_Wr_Active,
    output logic [2:0] o_Pixel_Color,
    output logic       o_Frame_Start
);

    localparam int N_OBJ = ID_EBULLET0 + N_EBULLET;

    obj_rec_t         staging_r [N_OBJ];
    obj_rec_t         shadow_r  [N_OBJ];

    logic             commit_s;
    logic             wr_fire_s;
    logic [N_OBJ-1:0] hit_s;
    logic             in_disp_s;
    logic [N_OBJ-1:0] hit_r;
    logic             in_disp_r;
    logic             s1_valid_r;
    logic             ebullet_any_s;
    logic [2:0]       color_s;
    logic [2:0]       color_r;
    logic             frame_start_r;

    // Ready drops only in the commit cycle so a write never races the copy;
    // a held write is taken the next cycle into the following frame's staging.
    assign commit_s   = i_Pix_En && (i_Pix_X == 10'd0) && (i_Pix_Y == 10'(V_DISPLAY));
    assign o_Wr_Ready = ~commit_s;
    assign wr_fire_s  = i_Wr_Valid && ~commit_s;

    // Staging bank: update port writes; ids beyond the last object are dropped
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            for (int i = 0; i < N_OBJ; i++) begin
                staging_r[i] <= OBJ_RESET;
            end
        end else if (wr_fire_s) begin
            for (int i = 0; i < N_OBJ; i++) begin
                if (i_Wr_Id == 4'(i)) begin
                    staging_r[i] <= '{active: i_Wr_Active, x: i_Wr_X, y: i_Wr_Y};
                end
            end
        end
    end

    // Shadow bank: whole-bank copy from staging at the start of blanking
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            for (int i = 0; i < N_OBJ; i++) begin
                shadow_r[i] <= OBJ_RESET;
            end
        end else if (commit_s) begin
            shadow_r <= staging_r;
        end
    end

    sprite_hit #(.W(PLAYER_W), .H(PLAYER_H)) u_hit_player (
        .pix_x      (i_Pix_X),
        .pix_y      (i_Pix_Y),
        .obj_active (shadow_r[ID_PLAYER].active),
        .obj_x      (shadow_r[ID_PLAYER].x),
        .obj_y      (shadow_r[ID_PLAYER].y),
        .hit        (hit_s[ID_PLAYER])
    );

    sprite_hit #(.W(BULLET_W), .H(BULLET_H)) u_hit_pbullet (
        .pix_x      (i_Pix_X),
        .pix_y      (i_Pix_Y),
        .obj_active (shadow_r[ID_PBULLET].active),
        .obj_x      (shadow_r[ID_PBULLET].x),
        .obj_y      (shadow_r[ID_PBULLET].y),
        .hit        (hit_s[ID_PBULLET])
    );

    sprite_hit #(.W(ENEMY_W), .H(ENEMY_H)) u_hit_enemy (
        .pix_x      (i_Pix_X),
        .pix_y      (i_Pix_Y),
        .obj_active (shadow_r[ID_ENEMY].active),
        .obj_x      (shadow_r[ID_ENEMY].x),
        .obj_y      (shadow_r[ID_ENEMY].y),
        .hit        (hit_s[ID_ENEMY])
    );

    for (genvar g = 0; g < N_EBULLET; g++) begin : g_ebullet
        sprite_hit #(.W(BULLET_W), .H(BULLET_H)) u_hit_ebullet (
            .pix_x      (i_Pix_X),
            .pix_y      (i_Pix_Y),
            .obj_active (shadow_r[ID_EBULLET0 + g].active),
            .obj_x      (shadow_r[ID_EBULLET0 + g].x),
            .obj_y      (shadow_r[ID_EBULLET0 + g].y),
            .hit        (hit_s[ID_EBULLET0 + g])
        );
    end

    assign in_disp_s = (i_Pix_X < 10'(H_DISPLAY)) && (i_Pix_Y < 10'(V_DISPLAY));

    // Stage 1: capture hit vector and in-display flag on each pixel strobe
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            hit_r      <= '0;
            in_disp_r  <= 1'b0;
            s1_valid_r <= 1'b0;
        end else if (i_Pix_En) begin
            hit_r      <= hit_s;
            in_disp_r  <= in_disp_s;
            s1_valid_r <= 1'b1;
        end
    end

    // Priority select: player bullet, enemy bullet, player, enemy, background
    always_comb begin
        ebullet_any_s = |hit_r[N_OBJ-1:ID_EBULLET0];
        color_s       = COL_BG;
        if (!in_disp_r) begin
            color_s = COL_BG;
        end else if (hit_r[ID_PBULLET]) begin
            color_s = COL_PBULLET;
        end else if (ebullet_any_s) begin
            color_s = COL_EBULLET;
        end else if (hit_r[ID_PLAYER]) begin
            color_s = COL_PLAYER;
        end else if (hit_r[ID_ENEMY]) begin
            color_s = COL_ENEMY;
        end else begin
            color_s = COL_BG;
        end
    end

    // Stage 2: register the colour; advances with the strobe so a paused
    // pixel stream freezes the output
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            color_r <= COL_BG;
        end else if (i_Pix_En && s1_valid_r) begin
            color_r <= color_s;
        end
    end

    // Frame-start pulse in the cycle after the commit
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= commit_s;
        end
    end

    assign o_Pixel_Color = color_r;
    assign o_Frame_Start = frame_start_r;

endmodule

// File: tb/tb_pixel_color_gen.sv
// Self-checking bench for pixel_color_gen. A reference model of the two
// object banks computes the colour for every strobed pixel; the result is
// queued and compared when the DUT presents it one strobe later.
module tb_pixel_color_gen;

    localparam int N_OBJ = 7;

    logic       i_Clk = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Pix_En = 1'b0;
    logic [9:0] i_Pix_X = 10'd0;
    logic [9:0] i_Pix_Y = 10'd0;
    logic       i_Wr_Valid = 1'b0;
    logic       o_Wr_Ready;
    logic [3:0] i_Wr_Id = 4'd0;
    logic [9:0] i_Wr_X = 10'd0;
    logic [9:0] i_Wr_Y = 10'd0;
    logic       i_Wr_Active = 1'b0;
    logic [2:0] o_Pixel_Color;
    logic       o_Frame_Start;

    pixel_color_gen #(.N_EBULLET(4)) dut (
        .i_Clk         (i_Clk),
        .i_Reset       (i_Reset),
        .i_Pix_En      (i_Pix_En),
        .i_Pix_X       (i_Pix_X),
        .i_Pix_Y       (i_Pix_Y),
        .i_Wr_Valid    (i_Wr_Valid),
        .o_Wr_Ready    (o_Wr_Ready),
        .i_Wr_Id       (i_Wr_Id),
        .i_Wr_X        (i_Wr_X),
        .i_Wr_Y        (i_Wr_Y),
        .i_Wr_Active   (i_Wr_Active),
        .o_Pixel_Color (o_Pixel_Color),
        .o_Frame_Start (o_Frame_Start)
    );

    always #5 i_Clk = ~i_Clk;

    int n_checks = 0;
    int n_fail   = 0;

    int st_a [N_OBJ];
    int st_x [N_OBJ];
    int st_y [N_OBJ];
    int sh_a [N_OBJ];
    int sh_x [N_OBJ];
    int sh_y [N_OBJ];

    logic [2:0] exp_q [$];
    logic [2:0] last_exp = 3'b000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_obj(input int i, input int x, input int y, input int w, input int h);
        return (sh_a[i] != 0) && (x >= sh_x[i]) && (x < sh_x[i] + w) &&
               (y >= sh_y[i]) && (y < sh_y[i] + h);
    endfunction

    function automatic logic [2:0] model_color(input int x, input int y);
        if (x >= 640 || y >= 480) return 3'b000;
        if (in_obj(1, x, y, 4, 8)) return 3'b010;
        for (int i = 3; i < N_OBJ; i++) begin
            if (in_obj(i, x, y, 4, 8)) return 3'b011;
        end
        if (in_obj(0, x, y, 32, 16)) return 3'b001;
        if (in_obj(2, x, y, 32, 16)) return 3'b100;
        return 3'b000;
    endfunction

    // One clock cycle of stimulus; called at a falling edge, returns at the next one
    task automatic step(input bit en, input int x, input int y,
                        input bit wv, input int id, input int wx, input int wy, input bit wa);
        bit commit;
        i_Pix_En    = en;
        i_Pix_X     = 10'(x);
        i_Pix_Y     = 10'(y);
        i_Wr_Valid  = wv;
        i_Wr_Id     = 4'(id);
        i_Wr_X      = 10'(wx);
        i_Wr_Y      = 10'(wy);
        i_Wr_Active = wa;
        #1;
        commit = en && (x == 0) && (y == 480);
        chk("wr_ready", {31'd0, o_Wr_Ready}, {31'd0, !commit});
        if (en) exp_q.push_back(model_color(x, y));
        if (wv && !commit && id < N_OBJ) begin
            st_a[id] = wa;
            st_x[id] = wx;
            st_y[id] = wy;
        end
        if (commit) begin
            sh_a = st_a;
            sh_x = st_x;
            sh_y = st_y;
        end
        @(negedge i_Clk);
        chk("frame_start", {31'd0, o_Frame_Start}, {31'd0, commit});
        if (en && exp_q.size() == 2) last_exp = exp_q.pop_front();
        chk($sformatf("color(%0d,%0d)", x, y), {29'd0, o_Pixel_Color}, {29'd0, last_exp});
    endtask

    task automatic px(input int x, input int y);
        step(1'b1, x, y, 1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic wr(input int id, input int x, input int y, input bit a);
        step(1'b1, 700, 500, 1'b1, id, x, y, a);
    endtask

    task automatic commit_frame();
        px(639, 479);
        px(0, 480);
        px(1, 480);
    endtask

    task automatic grid();
        for (int y = 0; y < 480; y += 48) begin
            for (int x = 0; x < 640; x += 40) begin
                px(x, y);
            end
        end
        px(639, 479);
        px(640, 0);
    endtask

    task automatic do_reset();
        i_Reset    = 1'b1;
        i_Pix_En   = 1'b0;
        i_Wr_Valid = 1'b0;
        @(negedge i_Clk);
        i_Reset = 1'b0;
        for (int i = 0; i < N_OBJ; i++) begin
            st_a[i] = 0; st_x[i] = 0; st_y[i] = 0;
            sh_a[i] = 0; sh_x[i] = 0; sh_y[i] = 0;
        end
        exp_q.delete();
        last_exp = 3'b000;
        chk("rst_color", {29'd0, o_Pixel_Color}, 32'd0);
        chk("rst_frame_start", {31'd0, o_Frame_Start}, 32'd0);
        #1;
        chk("rst_wr_ready", {31'd0, o_Wr_Ready}, 32'd1);
    endtask

    initial begin
        @(negedge i_Clk);
        do_reset();

        // Empty frames: background everywhere, one frame-start per commit
        grid();
        commit_frame();
        grid();
        commit_frame();

        // Player appears only after the commit
        wr(0, 100, 200, 1'b1);
        px(100, 200);
        px(131, 215);
        commit_frame();
        px(100, 200);
        px(131, 215);
        px(132, 200);
        px(100, 216);
        px(99, 200);
        px(100, 199);

        // Overlap priority
        wr(1, 110, 205, 1'b1);
        wr(3, 110, 205, 1'b1);
        commit_frame();
        px(111, 206);
        px(113, 212);
        px(114, 206);
        wr(1, 110, 205, 1'b0);
        commit_frame();
        px(111, 206);
        wr(3, 110, 205, 1'b0);
        commit_frame();
        px(111, 206);

        // Last write to an id within a frame wins
        wr(6, 10, 10, 1'b1);
        wr(6, 50, 60, 1'b1);
        commit_frame();
        px(10, 10);
        px(51, 61);

        // Write held across the commit cycle lands in the next frame
        px(639, 479);
        step(1'b1, 0, 480, 1'b1, 2, 300, 300, 1'b1);
        step(1'b1, 1, 480, 1'b1, 2, 300, 300, 1'b1);
        px(305, 305);
        commit_frame();
        px(305, 305);

        // Enemy at the bottom-right corner, no wrap; id 15 ignored
        wr(2, 630, 470, 1'b1);
        wr(15, 0, 470, 1'b1);
        commit_frame();
        px(639, 479);
        px(640, 470);
        px(0, 470);
        px(5, 475);
        px(630, 470);
        px(639, 479);
        px(639, 479);

        // Paused strobe: output holds
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
        end
        px(0, 0);

        // Mid-line reset with objects active
        wr(0, 100, 200, 1'b1);
        commit_frame();
        px(100, 200);
        px(101, 200);
        px(639, 479);
        do_reset();
        px(639, 479);
        px(100, 200);
        commit_frame();
        px(100, 200);
        px(639, 479);
        grid();

        px(700, 500);
        px(700, 500);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach the end");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pixel_color_gen.md
# pixel_color_gen

Upstream stage of the VGA monitor timing block: turns the current pixel coordinate into the 3-bit colour code that the monitor maps to RGB. Holds the positions of the shooter-game objects (player, player bullet, enemy, enemy bullets), accepts position updates from game logic at any time, and commits them only at the start of vertical blanking so a frame never tears. The hit test and priority select are pipelined; game logic and the timing block stay decoupled.

## Interface
- H_DISPLAY, 640, visible width in pixels
- V_DISPLAY, 480, visible height in lines
- PLAYER_W / PLAYER_H, 32 / 16, player sprite size
- ENEMY_W / ENEMY_H, 32 / 16, enemy sprite size
- BULLET_W / BULLET_H, 4 / 8, size of both bullet types
- N_EBULLET, 4, number of enemy bullets (1..12)

- i_Clk  in  1  pixel-domain clock; all logic on its rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_Pix_En  in  1  pixel strobe: i_Pix_X/i_Pix_Y valid this cycle
- i_Pix_X  in  10  current pixel column
- i_Pix_Y  in  10  current pixel line
- i_Wr_Valid  in  1  object update request
- o_Wr_Ready  out  1  update accepted when Valid & Ready
- i_Wr_Id  in  4  object id: 0 player, 1 player bullet, 2 enemy, 3..3+N_EBULLET-1 enemy bullets
- i_Wr_X / i_Wr_Y  in  10 / 10  object top-left corner
- i_Wr_Active  in  1  object visible
- o_Pixel_Color  out  3  colour code to monitor
- o_Frame_Start  out  1  one-cycle pulse on commit

## Operation
- Two register banks per object {active, x, y}: staging (written by the update port) and shadow (used for drawing).
- Update port: on Valid & Ready, staging[Id] ← {Active, X, Y}. Ids ≥ 3+N_EBULLET are accepted and dropped. Repeated writes to one id in a frame: last one wins.
- Commit: when i_Pix_En & i_Pix_X==0 & i_Pix_Y==V_DISPLAY, shadow ← staging for all objects in one cycle, o_Frame_Start=1 in the following cycle. o_Wr_Ready is 0 in the commit cycle only (combinational from the commit condition), so a write never races a commit; the writer holds Valid and the write lands in the next frame's staging.
- Hit test per object: hit = active & X ≥ ox & X < ox+W & Y ≥ oy & Y < oy+H. Sums use 11-bit width (no 10-bit wrap). Objects overrunning the right or bottom edge are clipped naturally.
- Priority (highest first): player bullet 3'b010, enemy bullet 3'b011, player 3'b001, enemy 3'b100, background 3'b000.
- Pixels with X ≥ H_DISPLAY or Y ≥ V_DISPLAY produce 3'b000.

## Timing
- Stage 1 (on i_Pix_En): register per-object hit vector and the in-display flag.
- Stage 2 (on a valid stage-1 entry): register the priority-encoded colour into o_Pixel_Color.
- Latency: colour for the coordinate sampled at cycle t appears at t+2. With i_Pix_En low, both stages hold and o_Pixel_Color keeps its value.
- Shadow changes take effect from the first pixel strobe after the commit cycle. Commit is in blanking, so the visible frame is always self-consistent.
- Reset, including mid-frame: staging and shadow all inactive at (0,0); pipeline cleared. The next cycle gives o_Pixel_Color=000, o_Frame_Start=0 and o_Wr_Ready=1 (commit condition false).

## Structure
- Package pixel_color_pkg: colour-code constants (COL_BG, COL_PLAYER, COL_PBULLET, COL_EBULLET, COL_ENEMY), object-id constants, the default sprite sizes, and the object-record typedef {active, x, y}.
- Sub-module sprite_hit: one object's range compare (parameters W and H; inputs pixel X/Y and the shadow record; output hit). Instantiated 3+N_EBULLET times. Priority encode and banks stay in the top module.

## Test plan
- Reset, then sweep a full frame with no writes → o_Pixel_Color 000 everywhere; o_Frame_Start pulses once per frame at line 480 column 0.
- Write player id0 at (100,200) active and run to the commit → next frame: pixel (100,200) and (131,215) give 001; (132,200) and (100,216) give 000; the current frame is unaffected.
- Overlap: player at (100,200), player bullet id1 at (110,205), enemy bullet id3 at (110,205) → pixel (111,206) gives 010. Deactivate id1 → 011. Then deactivate id3 → 001.
- Hold i_Wr_Valid through the commit cycle → o_Wr_Ready=0 that cycle only. The write is accepted the next cycle and becomes visible one frame later.
- Enemy id2 at (630,470) → pixel (639,479) gives 100; pixel (640,470) gives 000 with no wrap to column 0. Write id 15 → accepted, no effect.
- Assert i_Reset mid-line with objects active → output 000 from the next cycle; objects stay invisible after the following commit.
